// File: rtl/load_store_unit.sv
// Data-memory access stage: runs one req/ready/rvalid bus transaction per load/store,
// formats load results for write-back and stalls the core until the access completes.
module load_store_unit #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [4:0]  ls_op,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   localparam logic [4:0] OP_LB  = 5'b01010;
   localparam logic [4:0] OP_LH  = 5'b01011;
   localparam logic [4:0] OP_LW  = 5'b01100;
   localparam logic [4:0] OP_LBU = 5'b01101;
   localparam logic [4:0] OP_LHU = 5'b01110;
   localparam logic [4:0] OP_SB  = 5'b01111;
   localparam logic [4:0] OP_SH  = 5'b10000;
   localparam logic [4:0] OP_SW  = 5'b10001;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] load_q, load_d;
   logic [15:0] cnt_q, cnt_d;
   logic        mis_q, mis_d;
   logic        berr_q, berr_d;

   // Request decode of the incoming op
   logic        op_valid;
   logic        in_store;
   logic [1:0]  in_size;
   logic        in_aligned;
   logic [3:0]  in_be;
   logic [31:0] in_wdata;

   always_comb begin
      op_valid = 1'b0;
      in_store = 1'b0;
      in_size  = SZ_BYTE;
      case (ls_op)
         OP_LB, OP_LBU: begin op_valid = 1'b1; in_size = SZ_BYTE; end
         OP_LH, OP_LHU: begin op_valid = 1'b1; in_size = SZ_HALF; end
         OP_LW:         begin op_valid = 1'b1; in_size = SZ_WORD; end
         OP_SB:         begin op_valid = 1'b1; in_store = 1'b1; in_size = SZ_BYTE; end
         OP_SH:         begin op_valid = 1'b1; in_store = 1'b1; in_size = SZ_HALF; end
         OP_SW:         begin op_valid = 1'b1; in_store = 1'b1; in_size = SZ_WORD; end
         default:       ;
      endcase
   end

   always_comb begin
      in_aligned = 1'b1;
      in_be      = 4'b1111;
      in_wdata   = store_data;
      case (in_size)
         SZ_BYTE: begin
            in_be    = 4'b0001 << addr[1:0];
            in_wdata = {4{store_data[7:0]}};
         end
         SZ_HALF: begin
            in_aligned = ~addr[0];
            in_be      = addr[1] ? 4'b1100 : 4'b0011;
            in_wdata   = {2{store_data[15:0]}};
         end
         default: begin
            in_aligned = (addr[1:0] == 2'b00);
         end
      endcase
   end

   // Load formatting from the captured address lane
   logic [31:0] rd_shift;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] rd_fmt;

   always_comb begin
      rd_shift = dmem_rdata >> {addr_q[1:0], 3'b000};
      rd_byte  = rd_shift[7:0];
      rd_half  = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (op_q)
         OP_LB:   rd_fmt = {{24{rd_byte[7]}}, rd_byte};
         OP_LBU:  rd_fmt = {24'h000000, rd_byte};
         OP_LH:   rd_fmt = {{16{rd_half[15]}}, rd_half};
         OP_LHU:  rd_fmt = {16'h0000, rd_half};
         default: rd_fmt = dmem_rdata;
      endcase
   end

   // Timeout fires on the cycle whose count reaches the limit; ready/rvalid that cycle wins
   logic [15:0] cnt_inc;
   logic        tmo;

   always_comb begin
      cnt_inc = cnt_q + 16'd1;
      tmo     = (TIMEOUT_CYCLES != 16'd0) && (cnt_inc >= TIMEOUT_CYCLES);
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      we_d    = we_q;
      size_d  = size_q;
      load_d  = load_q;
      cnt_d   = cnt_q;
      mis_d   = mis_q;
      berr_d  = berr_q;
      case (state_q)
         S_IDLE: begin
            if (start && op_valid) begin
               op_d    = ls_op;
               addr_d  = addr;
               wdata_d = in_wdata;
               be_d    = in_be;
               we_d    = in_store;
               size_d  = in_size;
               cnt_d   = '0;
               berr_d  = 1'b0;
               mis_d   = ~in_aligned;
               state_d = in_aligned ? S_REQ : S_ERR;
            end
         end
         S_REQ: begin
            cnt_d = cnt_inc;
            if (dmem_ready) begin
               state_d = we_q ? S_DONE : S_WAIT;
            end else if (tmo) begin
               berr_d  = 1'b1;
               state_d = S_ERR;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (dmem_rvalid) begin
               load_d  = rd_fmt;
               state_d = S_DONE;
            end else if (tmo) begin
               berr_d  = 1'b1;
               state_d = S_ERR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         size_q  <= '0;
         load_q  <= '0;
         cnt_q   <= '0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         size_q  <= size_d;
         load_q  <= load_d;
         cnt_q   <= cnt_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   always_comb begin
      busy       = (state_q != S_IDLE);
      stall      = busy | (start & op_valid);
      done       = (state_q == S_DONE) || (state_q == S_ERR);
      misaligned = (state_q == S_ERR) && mis_q;
      bus_err    = (state_q == S_ERR) && berr_q;
      load_data  = load_q;
      dmem_req   = (state_q == S_REQ);
      dmem_we    = we_q;
      dmem_addr  = {addr_q[31:2], 2'b00};
      dmem_wdata = wdata_q;
      dmem_be    = be_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized accesses against a
// spec-level reference model, and hand sequences for invalid op and mid-access reset.
module tb_load_store_unit;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  ls_op = '0;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic        stall, busy, done, misaligned, bus_err;
   logic [31:0] load_data;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(16'd8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ls_op(ls_op), .addr(addr),
      .store_data(store_data), .stall(stall), .busy(busy), .done(done),
      .load_data(load_data), .misaligned(misaligned), .bus_err(bus_err),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
   );

   typedef struct {
      logic [4:0]  op;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] rdata;
      int          r;      // idle REQ cycles before ready
      int          v;      // WAIT cycles until rvalid (>=1)
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld;
      logic        mis;
      logic        err;
   } vec_t;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_load(input logic [4:0] op);
      return op <= 5'b01110;
   endfunction

   function automatic int nbytes(input logic [4:0] op);
      case (op)
         5'b01010, 5'b01101, 5'b01111: return 1;
         5'b01011, 5'b01110, 5'b10000: return 2;
         default:                      return 4;
      endcase
   endfunction

   // Cycle (1-based after start) at which the timeout hits, 0 if the access completes
   function automatic int tmo_cycle(input bit ld, input int r, input int v);
      int last;
      last = ld ? r + v + 1 : r + 1;
      for (int n = TO; n <= last; n++)
         if (n != r + 1 && !(ld && n == r + v + 1)) return n;
      return 0;
   endfunction

   logic [31:0] last_load = '0;

   function automatic vec_t build_exp(input vec_t t);
      vec_t e;
      int nb;
      logic [31:0] sh;
      logic [31:0] val;
      e = t;
      nb = nbytes(t.op);
      e.be = 4'((4'((1 << nb) - 1)) << t.addr[1:0]);
      e.mis = (int'(t.addr[1:0]) % nb) != 0;
      case (nb)
         1:       e.wdata = {4{t.sd[7:0]}};
         2:       e.wdata = {2{t.sd[15:0]}};
         default: e.wdata = t.sd;
      endcase
      e.err = !e.mis && (tmo_cycle(is_load(t.op), t.r, t.v) != 0);
      sh = t.rdata >> (8 * int'(t.addr[1:0]));
      case (t.op)
         5'b01010: val = 32'($signed(sh[7:0]));
         5'b01101: val = {24'h0, sh[7:0]};
         5'b01011: val = 32'($signed(sh[15:0]));
         5'b01110: val = {16'h0, sh[15:0]};
         default:  val = t.rdata;
      endcase
      e.ld = (is_load(t.op) && !e.mis && !e.err) ? val : last_load;
      return e;
   endfunction

   task automatic run_access(input vec_t t);
      int dc, tc;
      bit ld;
      bit req_exp;
      ld = is_load(t.op);
      tc = t.mis ? 0 : tmo_cycle(ld, t.r, t.v);
      if (t.mis) dc = 1;
      else if (tc != 0) dc = tc + 1;
      else dc = ld ? t.r + t.v + 2 : t.r + 2;
      @(negedge clk);
      start = 1'b1; ls_op = t.op; addr = t.addr; store_data = t.sd;
      #1;
      chk1("stall_at_start", stall, 1'b1);
      chk1("busy_at_start", busy, 1'b0);
      for (int n = 1; n <= dc; n++) begin
         @(negedge clk);
         start = 1'b0; ls_op = 5'($urandom); addr = $urandom; store_data = $urandom;
         dmem_ready  = (n == t.r + 1);
         dmem_rvalid = ld && (n == t.r + t.v + 1);
         dmem_rdata  = dmem_rvalid ? t.rdata : $urandom;
         #1;
         req_exp = !t.mis && (n <= t.r + 1) && (tc == 0 || n <= tc);
         chk1("done", done, n == dc);
         chk1("dmem_req", dmem_req, req_exp);
         if (req_exp) begin
            chk32("dmem_addr", dmem_addr, {t.addr[31:2], 2'b00});
            chk32("dmem_be", {28'h0, dmem_be}, {28'h0, t.be});
            chk1("dmem_we", dmem_we, !ld);
            if (!ld) chk32("dmem_wdata", dmem_wdata, t.wdata);
         end
         if (n == dc) begin
            chk1("misaligned", misaligned, t.mis);
            chk1("bus_err", bus_err, t.err);
            chk32("load_data", load_data, t.ld);
         end
      end
      dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      last_load = t.ld;
   endtask

   vec_t tbl[12];
   vec_t rv;
   logic [4:0] ops[8];

   initial begin
      //        op        addr          sd            rdata         r  v   be       wdata         ld            mis   err
      tbl[0]  = '{5'b01010, 32'h0000_1003, 32'h0,        32'h80FF_FF12, 0, 1,  4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0};
      tbl[1]  = '{5'b01110, 32'h0000_1002, 32'h0,        32'hBEEF_1234, 1, 2,  4'b1100, 32'h0,        32'h0000_BEEF, 1'b0, 1'b0};
      tbl[2]  = '{5'b01011, 32'h0000_1002, 32'h0,        32'hBEEF_1234, 0, 1,  4'b1100, 32'h0,        32'hFFFF_BEEF, 1'b0, 1'b0};
      tbl[3]  = '{5'b10000, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        0, 1,  4'b1100, 32'hABCD_ABCD, 32'hFFFF_BEEF, 1'b0, 1'b0};
      tbl[4]  = '{5'b01100, 32'h0000_1001, 32'h0,        32'h1111_1111, 0, 1,  4'b1111, 32'h0,        32'hFFFF_BEEF, 1'b1, 1'b0};
      tbl[5]  = '{5'b10001, 32'h0000_4000, 32'h1234_5678, 32'h0,        3, 1,  4'b1111, 32'h1234_5678, 32'hFFFF_BEEF, 1'b0, 1'b0};
      tbl[6]  = '{5'b01100, 32'h0000_5000, 32'h0,        32'h2222_2222, 0, 30, 4'b1111, 32'h0,        32'hFFFF_BEEF, 1'b0, 1'b1};
      tbl[7]  = '{5'b01111, 32'h0000_6001, 32'h0000_00A5, 32'h0,        0, 1,  4'b0010, 32'hA5A5_A5A5, 32'hFFFF_BEEF, 1'b0, 1'b0};
      tbl[8]  = '{5'b01101, 32'h0000_6002, 32'h0,        32'h00F0_0000, 2, 3,  4'b0100, 32'h0,        32'h0000_00F0, 1'b0, 1'b0};
      tbl[9]  = '{5'b10001, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0,        7, 1,  4'b1111, 32'hDEAD_BEEF, 32'h0000_00F0, 1'b0, 1'b0};
      tbl[10] = '{5'b01100, 32'h0000_7004, 32'h0,        32'hCAFE_F00D, 7, 1,  4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0, 1'b0};
      tbl[11] = '{5'b10001, 32'h0000_7008, 32'h0BAD_0BAD, 32'h0,        8, 1,  4'b1111, 32'h0BAD_0BAD, 32'hCAFE_F00D, 1'b0, 1'b1};
      ops = '{5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b10001};

      #1;
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_req", dmem_req, 1'b0);
      chk32("reset_load_data", load_data, 32'h0);
      chk32("reset_dmem_addr", dmem_addr, 32'h0);
      chk1("reset_stall", stall, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_access(tbl[i]);

      // Invalid op with start is ignored
      @(negedge clk);
      start = 1'b1; ls_op = 5'b00011; addr = 32'h100;
      #1 chk1("invalid_stall", stall, 1'b0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk1("invalid_busy", busy, 1'b0);
      chk1("invalid_done", done, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rv.op = ops[$urandom_range(0, 7)];
         rv.addr = $urandom; rv.sd = $urandom; rv.rdata = $urandom;
         rv.r = int'($urandom_range(0, 4)); rv.v = int'($urandom_range(1, 4));
         run_access(build_exp(rv));
      end

      // Reset while waiting for read data aborts the access
      @(negedge clk);
      start = 1'b1; ls_op = 5'b01100; addr = 32'h0000_8000;
      @(negedge clk);
      start = 1'b0; dmem_ready = 1'b1;
      #1 chk1("abort_req_before", dmem_req, 1'b1);
      @(negedge clk);
      dmem_ready = 1'b0;
      #1 chk1("abort_busy_wait", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("abort_req", dmem_req, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_done", done, 1'b0);
      chk32("abort_load_data", load_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
      #1;
      chk1("late_rvalid_busy", busy, 1'b0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      #1;
      chk1("late_rvalid_done", done, 1'b0);
      chk32("late_rvalid_load", load_data, 32'h0);
      last_load = '0;
      rv = '{5'b01101, 32'h0000_3001, 32'h0, 32'h0000_F100, 0, 1, 4'b0010, 32'h0, 32'h0000_00F1, 1'b0, 1'b0};
      run_access(rv);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
